// File: rtl/ibr128_stream_ctrl.sv
// Purpose: streams 32-bit words into 128-bit blocks for an opmode cipher core and streams results back out.
// Latency: RUN starts the cycle after the 4th input word; the first output word is valid the cycle after cipherReady.
// Backpressure: inReady is low from the 4th input word until the 4th output word; outData holds while outReady=0.
//
// Ports:
//   Clk, RstN                 - rising-edge clock, asynchronous active-low reset
//   inValid/inData/inLast     - upstream words (inLast sampled on the 4th word of a block)
//   inReady                   - upstream accept
//   blkEnable/blkFB/blkText   - opmode Enable, first-block flag and 128-bit input block
//   cipherText/cipherReady    - opmode result and its valid strobe (only honoured in RUN)
//   outValid/outData/outLast  - downstream words, outLast on the 4th word of a final block
//   outReady                  - downstream accept
//   busy                      - high while a block is in RUN or DRAIN
//   timeoutErr                - sticky RUN timeout flag
// Optional feature: define IBR128_STREAM_TIMEOUT_EN to abort RUN after TIMEOUT_CYCLES cycles.
module ibr128_stream_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         Clk,
  input  logic         RstN,
  input  logic         inValid,
  input  logic [31:0]  inData,
  input  logic         inLast,
  output logic         inReady,
  output logic         blkEnable,
  output logic         blkFB,
  output logic [127:0] blkText,
  input  logic [127:0] cipherText,
  input  logic         cipherReady,
  output logic         outValid,
  output logic [31:0]  outData,
  output logic         outLast,
  input  logic         outReady,
  output logic         busy,
  output logic         timeoutErr
);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;

  logic [1:0]   state;
  logic [1:0]   in_cnt;
  logic [1:0]   out_cnt;
  logic         first_flag;
  logic         last_flag;
  logic         rdy_q;
  logic [127:0] text_q;
  logic [127:0] out_q;
  logic [31:0]  out_word;
  logic         in_fire;
  logic         out_fire;

`ifdef IBR128_STREAM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             tmo_err;

  // Counts RUN cycles; hit on the last permitted RUN cycle so Enable is high exactly TIMEOUT_CYCLES cycles.
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      tmo_cnt <= '0;
    end else if (state == S_RUN) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign timeoutErr = tmo_err;
`else
  assign timeoutErr = 1'b0;
`endif

  assign in_fire  = inValid && rdy_q;
  assign out_fire = (state == S_DRAIN) && outReady;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state      <= S_COLLECT;
      in_cnt     <= 2'd0;
      out_cnt    <= 2'd0;
      first_flag <= 1'b1;
      last_flag  <= 1'b0;
      rdy_q      <= 1'b0;
      text_q     <= '0;
      out_q      <= '0;
`ifdef IBR128_STREAM_TIMEOUT_EN
      tmo_err    <= 1'b0;
`endif
    end else begin
      case (state)
        S_COLLECT: begin
          // rdy_q is registered so that inReady stays low while reset is applied.
          rdy_q <= 1'b1;
          if (in_fire) begin
            case (in_cnt)
              2'd0:    text_q[127:96] <= inData;
              2'd1:    text_q[95:64]  <= inData;
              2'd2:    text_q[63:32]  <= inData;
              default: text_q[31:0]   <= inData;
            endcase
            in_cnt <= in_cnt + 2'd1;
            if (in_cnt == 2'd3) begin
              last_flag <= inLast;
              rdy_q     <= 1'b0;
              state     <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (cipherReady) begin
            out_q   <= cipherText;
            out_cnt <= 2'd0;
            state   <= S_DRAIN;
          end
`ifdef IBR128_STREAM_TIMEOUT_EN
          else if (tmo_hit) begin
            // Abandon the block; the next block restarts a message.
            tmo_err    <= 1'b1;
            first_flag <= 1'b1;
            rdy_q      <= 1'b1;
            state      <= S_COLLECT;
          end
`endif
        end
        S_DRAIN: begin
          if (out_fire) begin
            out_cnt <= out_cnt + 2'd1;
            if (out_cnt == 2'd3) begin
              first_flag <= last_flag;
              rdy_q      <= 1'b1;
              state      <= S_COLLECT;
            end
          end
        end
        default: begin
          state <= S_COLLECT;
        end
      endcase
    end
  end

  always_comb begin
    case (out_cnt)
      2'd0:    out_word = out_q[127:96];
      2'd1:    out_word = out_q[95:64];
      2'd2:    out_word = out_q[63:32];
      default: out_word = out_q[31:0];
    endcase
  end

  // Decoded straight from state so a reset drops Enable without waiting for a clock.
  assign inReady   = rdy_q;
  assign blkEnable = (state == S_RUN);
  assign blkFB     = (state == S_RUN) && first_flag;
  assign blkText   = text_q;
  assign outValid  = (state == S_DRAIN);
  assign outData   = (state == S_DRAIN) ? out_word : 32'd0;
  assign outLast   = (state == S_DRAIN) && (out_cnt == 2'd3) && last_flag;
  assign busy      = (state != S_COLLECT);

endmodule

// File: tb/tb_ibr128_stream_ctrl.sv
module tb_ibr128_stream_ctrl;

  logic         Clk = 1'b0;
  logic         RstN;
  logic         inValid;
  logic [31:0]  inData;
  logic         inLast;
  logic         inReady;
  logic         blkEnable;
  logic         blkFB;
  logic [127:0] blkText;
  logic [127:0] cipherText;
  logic         cipherReady;
  logic         outValid;
  logic [31:0]  outData;
  logic         outLast;
  logic         outReady;
  logic         busy;
  logic         timeoutErr;

  ibr128_stream_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .Clk(Clk), .RstN(RstN),
    .inValid(inValid), .inData(inData), .inLast(inLast), .inReady(inReady),
    .blkEnable(blkEnable), .blkFB(blkFB), .blkText(blkText),
    .cipherText(cipherText), .cipherReady(cipherReady),
    .outValid(outValid), .outData(outData), .outLast(outLast), .outReady(outReady),
    .busy(busy), .timeoutErr(timeoutErr)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stimulus knobs shared with the cipher and sink behaviour.
  int rdy_delay = 10;
  bit never_rdy = 1'b0;
  bit use_const = 1'b1;
  bit stray_rdy = 1'b0;
  bit toggle_or = 1'b0;

  // Cipher core behaviour: result after rdy_delay RUN cycles; stray strobes only while idle.
  initial begin
    int cnt;
    cnt = 0;
    cipherReady = 1'b0;
    cipherText  = '0;
    forever begin
      @(posedge Clk); #1;
      if (!RstN) begin
        cnt = 0;
        cipherReady = 1'b0;
      end else if (blkEnable) begin
        cipherReady = 1'b0;
        if (!never_rdy) begin
          cnt++;
          if (cnt >= rdy_delay) begin
            cipherText  = use_const ? {4{32'hA5A5A5A5}} : ~blkText;
            cipherReady = 1'b1;
            cnt = 0;
          end
        end
      end else begin
        cnt = 0;
        cipherReady = stray_rdy;
        cipherText  = {4{32'hDEADBEEF}};
      end
    end
  end

  // Downstream sink.
  initial begin
    outReady = 1'b1;
    forever begin
      @(posedge Clk); #1;
      outReady = toggle_or ? ~outReady : 1'b1;
    end
  end

  // Reference model: one block in flight, described by what it must contain and produce.
  logic [31:0]  wq [4];
  int           in_k = 0;
  int           out_k = 0;
  logic [127:0] exp_text = '0;
  logic [127:0] exp_out = '0;
  logic [127:0] out_acc = '0;
  bit           exp_fb = 1'b0, exp_last = 1'b0;
  bit           have_blk = 1'b0, draining = 1'b0;
  bit           saw_cr = 1'b0, cr_prev = 1'b0, prev_be = 1'b0, prev_hold = 1'b0;
  bit           model_first = 1'b1;
  logic [31:0]  prev_data = '0;
  int           out_words = 0, out_lasts = 0;

  initial begin
    forever begin
      @(negedge Clk);
      if (!RstN) begin
        in_k = 0; out_k = 0; have_blk = 0; draining = 0;
        saw_cr = 0; cr_prev = 0; prev_be = 0; prev_hold = 0;
        model_first = 1'b1;
      end else begin
        if (cr_prev) begin
          chk("enable_drop_after_ready", blkEnable, 1'b0);
          chk("drain_entered", outValid, 1'b1);
          draining = 1'b1;
        end
        if (prev_be && !blkEnable && !saw_cr) begin
`ifdef IBR128_STREAM_TIMEOUT_EN
          chk("timeout_err_set", timeoutErr, 1'b1);
`else
          chk("unexpected_enable_drop", blkEnable, 1'b1);
`endif
          have_blk = 0;
          model_first = 1'b1;
        end
        if (!blkEnable) saw_cr = 0;
        if (blkEnable) begin
          chk("run_has_block", have_blk, 1'b1);
          chk("blkText", blkText, exp_text);
          chk("blkFB", blkFB, exp_fb);
          chk("inReady_run", inReady, 1'b0);
          if (cipherReady) saw_cr = 1'b1;
        end
        cr_prev = blkEnable && cipherReady;

        if (outValid) begin
          chk("inReady_drain", inReady, 1'b0);
          if (prev_hold) chk("outData_hold", outData, prev_data);
        end else begin
          chk("outLast_idle", outLast, 1'b0);
        end
        if (outValid && outReady) begin
          if (!draining) begin
            chk("unexpected_output", outValid, 1'b0);
          end else begin
            chk("outData", outData, exp_out[127-32*out_k -: 32]);
            chk("outLast", outLast, (out_k == 3) && exp_last);
            out_acc = {out_acc[95:0], outData};
            out_words++;
            if (outLast) out_lasts++;
            out_k++;
            if (out_k == 4) begin
              out_k = 0; draining = 0; have_blk = 0;
              model_first = exp_last;
            end
          end
        end
        prev_hold = outValid && !outReady;
        prev_data = outData;

        if (inValid && inReady) begin
          wq[in_k] = inData;
          in_k++;
          if (in_k == 4) begin
            exp_text = {wq[0], wq[1], wq[2], wq[3]};
            exp_fb   = model_first;
            exp_last = inLast;
            exp_out  = use_const ? {4{32'hA5A5A5A5}} : ~exp_text;
            have_blk = 1'b1;
            in_k = 0;
          end
        end
        prev_be = blkEnable;
      end
    end
  end

  task automatic send_word(input logic [31:0] w, input logic l);
    int n;
    n = 0;
    inValid = 1'b1;
    inData  = w;
    inLast  = l;
    forever begin
      @(negedge Clk);
      if (inReady) break;
      n++;
      if (n > 200) begin
        chk("input_accept_bound", inReady, 1'b1);
        break;
      end
    end
    @(posedge Clk); #1;
    inValid = 1'b0;
  endtask

  // inLast on words 0..2 is driven inverted to show it is ignored there.
  task automatic send_block(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3, input logic l);
    send_word(w0, ~l);
    send_word(w1, ~l);
    send_word(w2, ~l);
    send_word(w3, l);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(inReady && !busy) && n < 1000) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("idle_reached", inReady && !busy, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    RstN = 1'b0; inValid = 1'b0; inData = '0; inLast = 1'b0;
    #12;
    chk("rst_inReady", inReady, 1'b0);
    chk("rst_blkEnable", blkEnable, 1'b0);
    chk("rst_blkFB", blkFB, 1'b0);
    chk("rst_blkText", blkText, 128'd0);
    chk("rst_outValid", outValid, 1'b0);
    chk("rst_outData", outData, 32'd0);
    chk("rst_outLast", outLast, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeoutErr", timeoutErr, 1'b0);
    #5 RstN = 1'b1;
    @(posedge Clk); #1;
    chk("post_rst_inReady", inReady, 1'b1);

    // Single final block, constant cipher result after 10 cycles.
    use_const = 1'b1; rdy_delay = 10;
    send_block(32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF, 1'b1);
    chk("lit_blkText", blkText, 128'h00112233445566778899AABBCCDDEEFF);
    chk("lit_blkFB_first", blkFB, 1'b1);
    chk("lit_blkEnable_after_4th", blkEnable, 1'b1);
    chk("lit_busy_run", busy, 1'b1);
    chk("lit_inReady_run", inReady, 1'b0);
    wait_idle();
    chk("lit_words_blk1", out_words, 4);
    chk("lit_lasts_blk1", out_lasts, 1);
    chk("lit_out_blk1", out_acc, {4{32'hA5A5A5A5}});

    // Message of two blocks, then a new message.
    use_const = 1'b0; rdy_delay = 3;
    send_block(32'h01234567, 32'h89ABCDEF, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0);
    chk("lit_fb_msg_start", blkFB, 1'b1);
    wait_idle();
    send_block(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b1);
    chk("lit_fb_msg_cont", blkFB, 1'b0);
    wait_idle();
    send_block(32'hFFFFFFFF, 32'h00000000, 32'h12345678, 32'h87654321, 1'b1);
    chk("lit_fb_new_msg", blkFB, 1'b1);
    wait_idle();
    chk("lit_out_blkC", out_acc, 128'h00000000FFFFFFFFEDCBA987789ABCDE);
    chk("lit_words_16", out_words, 16);
    chk("lit_lasts_3", out_lasts, 3);

    // Stalling sink and stray cipherReady while idle.
    toggle_or = 1'b1; stray_rdy = 1'b1; rdy_delay = 2;
    send_block(32'hCAFEF00D, 32'h0BADC0DE, 32'h13579BDF, 32'h2468ACE0, 1'b1);
    wait_idle();
    toggle_or = 1'b0; stray_rdy = 1'b0;
    @(posedge Clk); #1;
    chk("lit_words_20", out_words, 20);

    // Reset in the middle of RUN.
    rdy_delay = 3;
    send_block(32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3, 1'b0);
    wait_idle();
    rdy_delay = 30;
    send_block(32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, 1'b0);
    chk("lit_fb_before_rst", blkFB, 1'b0);
    repeat (5) @(posedge Clk);
    #3 RstN = 1'b0;
    #1;
    chk("arst_blkEnable", blkEnable, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_outValid", outValid, 1'b0);
    chk("arst_blkText", blkText, 128'd0);
    chk("arst_inReady", inReady, 1'b0);
    @(posedge Clk); #3 RstN = 1'b1;
    @(posedge Clk); #1;
    rdy_delay = 3;
    send_block(32'h9ABCDEF0, 32'h12121212, 32'h34343434, 32'h56565656, 1'b1);
    chk("lit_fb_after_rst", blkFB, 1'b1);
    wait_idle();

`ifdef IBR128_STREAM_TIMEOUT_EN
    send_block(32'h10101010, 32'h20202020, 32'h30303030, 32'h40404040, 1'b0);
    wait_idle();
    never_rdy = 1'b1;
    send_block(32'h50505050, 32'h60606060, 32'h70707070, 32'h80808080, 1'b0);
    begin
      int n;
      n = 0;
      while (blkEnable && n < 100) begin
        chk("no_out_during_timeout", outValid, 1'b0);
        n++;
        @(posedge Clk); #1;
      end
      chk("lit_timeout_run_cycles", n, 16);
    end
    chk("lit_timeoutErr", timeoutErr, 1'b1);
    repeat (5) @(posedge Clk);
    #1;
    chk("lit_timeoutErr_sticky", timeoutErr, 1'b1);
    chk("lit_no_out_after_timeout", outValid, 1'b0);
    never_rdy = 1'b0;
    send_block(32'hAAAA5555, 32'h5555AAAA, 32'h0000FFFF, 32'hFFFF0000, 1'b1);
    chk("lit_fb_after_timeout", blkFB, 1'b1);
    wait_idle();
    chk("lit_timeoutErr_held", timeoutErr, 1'b1);
`else
    chk("timeoutErr_tied", timeoutErr, 1'b0);
`endif

    repeat (3) @(posedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
